mips_pass_done_monitor: RTL and testbench

- Receiving end of the pass_done interface: consumes MTC0Code events (MTC0_NOOP/PASS/FAIL/DONE) issued by the MIPS core and turns them into test-result status for the host/board logic.
- Keeps saturating pass/fail tallies, the index of the first failing check and the run cycle count, plus a watchdog.
- Presents one final report to the host through a valid/ready handshake, then halts.

---
 rtl/mips_pass_done_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_pass_done_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pass_done_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pass_done_monitor
//  Description : Receiving end of the MIPS pass_done interface. Consumes
//                MTC0Code events from the core, keeps saturating pass/fail
//                tallies, the index of the first failing check, the run
//                cycle count and an optional watchdog, then presents one
//                final report to the host via a valid/ready handshake and
//                halts until reset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    COUNT_W        width of pass/fail/index counters
//    CYCLE_W        width of the run cycle counter
//    TIMEOUT_CYCLES watchdog limit in cycles, 0 disables the watchdog
//  Ports
//    clk            system clock, all state on rising edge
//    rst_n          asynchronous active-low reset
//    mtc0_valid     MTC0 event strobe (one event per cycle)
//    mtc0_code      MTC0Code: 0=NOOP 1=PASS 2=FAIL 3=DONE
//    pass_count     accepted PASS events (saturating)
//    fail_count     accepted FAIL events (saturating)
//    first_fail_idx pass+fail count ahead of the first FAIL, all ones if none
//    any_fail       sticky, at least one FAIL accepted
//    cycle_count    cycles spent in RUN (saturating)
//    done           sticky, DONE received or watchdog fired
//    timed_out      run ended by the watchdog
//    report_valid   final report offered to the host
//    report_ready   host accepts the report
//    report_ok      qualifies the report: DONE, no FAIL, no timeout
//    late_event     sticky, non-NOOP event arrived after the run ended
// ============================================================================
module mips_pass_done_monitor #(
    parameter int COUNT_W        = 16,
    parameter int CYCLE_W        = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mtc0_valid,
    input  logic [1:0]         mtc0_code,
    output logic [COUNT_W-1:0] pass_count,
    output logic [COUNT_W-1:0] fail_count,
    output logic [COUNT_W-1:0] first_fail_idx,
    output logic               any_fail,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               done,
    output logic               timed_out,
    output logic               report_valid,
    input  logic               report_ready,
    output logic               report_ok,
    output logic               late_event
);

    // MTC0Code encoding shared with the core
    localparam logic [1:0] c_MTC0_NOOP = 2'd0;
    localparam logic [1:0] c_MTC0_PASS = 2'd1;
    localparam logic [1:0] c_MTC0_FAIL = 2'd2;
    localparam logic [1:0] c_MTC0_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPORT = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [COUNT_W-1:0]   r_pass_count;
    logic [COUNT_W-1:0]   r_fail_count;
    logic [COUNT_W-1:0]   r_first_fail_idx;
    logic                 r_any_fail;
    logic [CYCLE_W-1:0]   r_cycle_count;
    logic                 r_done;
    logic                 r_timed_out;
    logic                 r_report_valid;
    logic                 r_report_ok;
    logic                 r_late_event;

    logic                 w_accept;
    logic                 w_in_run;
    logic                 w_pass_ev;
    logic                 w_fail_ev;
    logic                 w_wd_hit;
    logic                 w_fire_done;
    logic                 w_fire_wd;
    logic                 w_late;
    logic                 w_enter_report;
    logic [COUNT_W:0]     w_idx_sum;
    logic [COUNT_W-1:0]   w_idx_sat;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_accept  = mtc0_valid && (mtc0_code != c_MTC0_NOOP);
    assign w_in_run  = (r_state == ST_RUN);
    assign w_pass_ev = w_in_run && w_accept && (mtc0_code == c_MTC0_PASS);
    assign w_fail_ev = w_in_run && w_accept && (mtc0_code == c_MTC0_FAIL);

    // Index of the first FAIL: the sum gets one extra bit so an overflow
    // saturates instead of wrapping to a small, misleading index.
    assign w_idx_sum = {1'b0, r_pass_count} + {1'b0, r_fail_count};
    assign w_idx_sat = w_idx_sum[COUNT_W] ? {COUNT_W{1'b1}} : w_idx_sum[COUNT_W-1:0];

    // ------------------------------------------------------------------
    // Watchdog: fires in the cycle whose count is TIMEOUT_CYCLES-1, so the
    // run ends with cycle_count == TIMEOUT_CYCLES.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_watchdog
            localparam logic [CYCLE_W-1:0] c_WD_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);
            assign w_wd_hit = (r_cycle_count == c_WD_LAST);
        end else begin : g_no_watchdog
            assign w_wd_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fire_done = 1'b0;
        w_fire_wd   = 1'b0;
        w_late      = 1'b0;
        case (r_state)
            ST_RUN: begin
                // DONE takes priority over a watchdog expiring in the same cycle
                if (w_accept && (mtc0_code == c_MTC0_DONE)) begin
                    w_fire_done = 1'b1;
                    w_state_nxt = ST_REPORT;
                end else if (w_wd_hit) begin
                    w_fire_wd   = 1'b1;
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_late = w_accept;
                if (report_ready) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_late = w_accept;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_enter_report = w_in_run && (w_state_nxt == ST_REPORT);

    // ------------------------------------------------------------------
    // Status datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_count     <= '0;
            r_fail_count     <= '0;
            r_first_fail_idx <= '1;
            r_any_fail       <= 1'b0;
            r_cycle_count    <= '0;
            r_done           <= 1'b0;
            r_timed_out      <= 1'b0;
            r_report_valid   <= 1'b0;
            r_report_ok      <= 1'b0;
            r_late_event     <= 1'b0;
        end else begin
            if (w_in_run && (r_cycle_count != {CYCLE_W{1'b1}})) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end

            if (w_pass_ev && (r_pass_count != {COUNT_W{1'b1}})) begin
                r_pass_count <= r_pass_count + 1'b1;
            end

            if (w_fail_ev) begin
                if (r_fail_count != {COUNT_W{1'b1}}) begin
                    r_fail_count <= r_fail_count + 1'b1;
                end
                if (!r_any_fail) begin
                    r_first_fail_idx <= w_idx_sat;
                end
                r_any_fail <= 1'b1;
            end

            if (w_fire_done || w_fire_wd) begin
                r_done <= 1'b1;
            end
            if (w_fire_wd) begin
                r_timed_out <= 1'b1;
            end

            r_report_valid <= (w_state_nxt == ST_REPORT);

            // FAIL and watchdog can land in the same cycle, so use the
            // post-update view of any_fail when latching the verdict.
            if (w_enter_report) begin
                r_report_ok <= ~(r_any_fail | w_fail_ev) & ~w_fire_wd;
            end

            if (w_late) begin
                r_late_event <= 1'b1;
            end
        end
    end

    assign pass_count     = r_pass_count;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail_idx;
    assign any_fail       = r_any_fail;
    assign cycle_count    = r_cycle_count;
    assign done           = r_done;
    assign timed_out      = r_timed_out;
    assign report_valid   = r_report_valid;
    assign report_ok      = r_report_ok;
    assign late_event     = r_late_event;

endmodule
`default_nettype wire

// File: tb/tb_mips_pass_done_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_pass_done_monitor
//  Description : Self-checking bench for mips_pass_done_monitor. Three
//                instances share stimulus: default config, a 10-cycle
//                watchdog config and a 4-bit counter config.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_pass_done_monitor;

    localparam logic [1:0] c_NOOP = 2'd0;
    localparam logic [1:0] c_PASS = 2'd1;
    localparam logic [1:0] c_FAIL = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic [1:0] code = 2'd0;
    logic       rdy = 1'b0;

    always #5 clk = ~clk;

    // default instance
    logic [15:0] d_pass, d_fail, d_idx;
    logic [31:0] d_cyc;
    logic        d_any, d_done, d_to, d_rv, d_ok, d_late;
    // watchdog instance
    logic [15:0] t_pass, t_fail, t_idx;
    logic [31:0] t_cyc;
    logic        t_any, t_done, t_to, t_rv, t_ok, t_late;
    // narrow-counter instance
    logic [3:0]  s_pass, s_fail, s_idx;
    logic [31:0] s_cyc;
    logic        s_any, s_done, s_to, s_rv, s_ok, s_late;

    mips_pass_done_monitor u_def (
        .clk(clk), .rst_n(rst_n), .mtc0_valid(vld), .mtc0_code(code),
        .pass_count(d_pass), .fail_count(d_fail), .first_fail_idx(d_idx),
        .any_fail(d_any), .cycle_count(d_cyc), .done(d_done), .timed_out(d_to),
        .report_valid(d_rv), .report_ready(rdy), .report_ok(d_ok), .late_event(d_late)
    );

    mips_pass_done_monitor #(.TIMEOUT_CYCLES(10)) u_to (
        .clk(clk), .rst_n(rst_n), .mtc0_valid(vld), .mtc0_code(code),
        .pass_count(t_pass), .fail_count(t_fail), .first_fail_idx(t_idx),
        .any_fail(t_any), .cycle_count(t_cyc), .done(t_done), .timed_out(t_to),
        .report_valid(t_rv), .report_ready(rdy), .report_ok(t_ok), .late_event(t_late)
    );

    mips_pass_done_monitor #(.COUNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .mtc0_valid(vld), .mtc0_code(code),
        .pass_count(s_pass), .fail_count(s_fail), .first_fail_idx(s_idx),
        .any_fail(s_any), .cycle_count(s_cyc), .done(s_done), .timed_out(s_to),
        .report_valid(s_rv), .report_ready(rdy), .report_ok(s_ok), .late_event(s_late)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  code;
        logic        rdy;
        logic [15:0] pass;
        logic [15:0] fail;
        logic [15:0] idx;
        logic        any;
        logic        done;
        logic        rv;
        logic        ok;
        logic        late;
        logic [31:0] cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c, input logic y,
                                input logic [15:0] p, input logic [15:0] f, input logic [15:0] ix,
                                input logic a, input logic dn, input logic rv, input logic ok,
                                input logic lt, input logic [31:0] cy);
        vec_t t;
        t.rst = r; t.vld = v; t.code = c; t.rdy = y;
        t.pass = p; t.fail = f; t.idx = ix; t.any = a; t.done = dn;
        t.rv = rv; t.ok = ok; t.late = lt; t.cyc = cy;
        return t;
    endfunction

    // Pulse reset over one cycle; returns at a negedge with rst_n released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        code  = c_NOOP;
        rdy   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive inputs at a negedge, clock once, return at the following negedge.
    task automatic step(input logic v, input logic [1:0] c, input logic y);
        vld  = v;
        code = c;
        rdy  = y;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // --- normal run: PASS x3, DONE, immediate ready, late event in HALTED
        tbl.push_back(mk(1, 1, c_PASS, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, c_PASS, 0, 2, 0, 16'hFFFF, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, c_PASS, 0, 3, 0, 16'hFFFF, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, c_DONE, 1, 3, 0, 16'hFFFF, 0, 1, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, c_NOOP, 1, 3, 0, 16'hFFFF, 0, 1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 1, c_PASS, 0, 3, 0, 16'hFFFF, 0, 1, 0, 1, 1, 4));
        // --- mixed run with FAILs, valid NOOP, held report, late event in REPORT
        tbl.push_back(mk(1, 1, c_PASS, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, c_PASS, 0, 2, 0, 16'hFFFF, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, c_FAIL, 0, 2, 1, 16'd2,    1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 1, c_NOOP, 0, 2, 1, 16'd2,    1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 1, c_PASS, 0, 3, 1, 16'd2,    1, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 1, c_FAIL, 0, 3, 2, 16'd2,    1, 0, 0, 0, 0, 6));
        tbl.push_back(mk(0, 1, c_DONE, 0, 3, 2, 16'd2,    1, 1, 1, 0, 0, 7));
        tbl.push_back(mk(0, 1, c_PASS, 0, 3, 2, 16'd2,    1, 1, 1, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 0, 3, 2, 16'd2,    1, 1, 1, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 0, 3, 2, 16'd2,    1, 1, 1, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 0, 3, 2, 16'd2,    1, 1, 1, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 0, 3, 2, 16'd2,    1, 1, 1, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 1, 3, 2, 16'd2,    1, 1, 0, 0, 1, 7));
        tbl.push_back(mk(0, 0, c_NOOP, 0, 3, 2, 16'd2,    1, 1, 0, 0, 1, 7));

        // --- reset values
        #12;
        chk("rst pass", d_pass, 0);
        chk("rst fail", d_fail, 0);
        chk("rst idx", d_idx, 16'hFFFF);
        chk("rst any", d_any, 0);
        chk("rst cyc", d_cyc, 0);
        chk("rst done", d_done, 0);
        chk("rst rv", d_rv, 0);
        chk("rst ok", d_ok, 0);
        chk("rst late", d_late, 0);
        chk("rst sat idx", s_idx, 4'hF);

        // --- table-driven vectors against the default instance
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].vld, tbl[i].code, tbl[i].rdy);
            chk($sformatf("v%0d pass", i), d_pass, tbl[i].pass);
            chk($sformatf("v%0d fail", i), d_fail, tbl[i].fail);
            chk($sformatf("v%0d idx", i),  d_idx,  tbl[i].idx);
            chk($sformatf("v%0d any", i),  d_any,  tbl[i].any);
            chk($sformatf("v%0d done", i), d_done, tbl[i].done);
            chk($sformatf("v%0d rv", i),   d_rv,   tbl[i].rv);
            chk($sformatf("v%0d ok", i),   d_ok,   tbl[i].ok);
            chk($sformatf("v%0d late", i), d_late, tbl[i].late);
            chk($sformatf("v%0d cyc", i),  d_cyc,  tbl[i].cyc);
            chk($sformatf("v%0d to", i),   d_to,   0);
        end

        // --- watchdog expiry with no events
        do_reset();
        repeat (9) step(0, c_NOOP, 0);
        chk("wd pre done", t_done, 0);
        chk("wd pre cyc", t_cyc, 9);
        step(0, c_NOOP, 0);
        chk("wd done", t_done, 1);
        chk("wd timed_out", t_to, 1);
        chk("wd rv", t_rv, 1);
        chk("wd ok", t_ok, 0);
        chk("wd cyc", t_cyc, 10);
        step(1, c_DONE, 0);
        chk("wd late", t_late, 1);
        chk("wd late cyc", t_cyc, 10);
        chk("wd late pass", t_pass, 0);
        chk("wd late to", t_to, 1);
        chk("wd late rv", t_rv, 1);

        // --- DONE in the same cycle the watchdog would fire
        do_reset();
        repeat (9) step(0, c_NOOP, 0);
        step(1, c_DONE, 0);
        chk("wd+done done", t_done, 1);
        chk("wd+done to", t_to, 0);
        chk("wd+done ok", t_ok, 1);

        // --- 4-bit counter saturation with interleaved valid NOOPs
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, c_PASS, 0);
            step(1, c_NOOP, 0);
        end
        chk("sat pass", s_pass, 4'hF);
        step(1, c_DONE, 1);
        chk("sat pass done", s_pass, 4'hF);
        chk("sat rv", s_rv, 1);
        chk("sat ok", s_ok, 1);
        chk("sat idx", s_idx, 4'hF);

        // --- asynchronous reset while the report is pending
        do_reset();
        step(1, c_PASS, 0);
        step(1, c_DONE, 0);
        chk("ar rv before", d_rv, 1);
        vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar rv", d_rv, 0);
        chk("ar done", d_done, 0);
        chk("ar pass", d_pass, 0);
        chk("ar cyc", d_cyc, 0);
        chk("ar idx", d_idx, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, c_PASS, 0);
        chk("ar fresh pass", d_pass, 1);
        chk("ar fresh cyc", d_cyc, 1);
        chk("ar fresh rv", d_rv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
